lights_cmd_ctrl: RTL and testbench
==================================

# lights_cmd_ctrl

Command front-end for the lights state memory: accepts word and single-bit light commands over a valid/ready interface and drives the write/read port of the 16-bit lights BRAM. It performs read-modify-write for bit set/clear/toggle, returns readback words, and provides a bulk clear. It sits directly upstream of the lights BRAM and is that memory's only master.

## Interface

Parameters:

- WIDTH, 16, word width of the lights BRAM; must be 16 (bit index is 4 bits).
- DEPTH, 2048, number of BRAM words; power of two.
- ADDR_W, $clog2(DEPTH) = 11, width of the command word address.

Ports:

- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept; high only in IDLE.
- cmd_op  in  3  operation (encodings below).
- cmd_addr  in  ADDR_W  word address.
- cmd_bit  in  4  bit index within word (bit ops only).
- cmd_data  in  WIDTH  write data (WRITE only).
- rsp_valid  out  1  one-cycle pulse, rsp_data valid (READ only).
- rsp_data  out  WIDTH  readback word; holds until next READ.
- err  out  1  one-cycle pulse on a reserved opcode.
- busy  out  1  high whenever state is not IDLE.
- mem_we  out  1  BRAM write enable.
- mem_addr  out  32  BRAM address, cmd_addr zero-extended.
- mem_din  out  WIDTH  BRAM write data.
- mem_dout  in  WIDTH  BRAM registered read data (1-cycle latency).

## Operation

- Opcodes: 0 READ, 1 WRITE, 2 SET, 3 CLR, 4 TGL, 5 CLEAR_ALL, 6–7 reserved.
- Accept on any rising edge with cmd_valid && cmd_ready; all command fields are latched at that edge.
- States: IDLE, RD, CAP, WR, CLR.
  - IDLE: cmd_ready=1. READ/SET/CLR/TGL go to RD. WRITE goes to WR. CLEAR_ALL goes to CLR with counter=0. Reserved ops stay in IDLE and set err for the next cycle.
  - RD: mem_addr=latched address, mem_we=0. READ goes to CAP; bit ops go to WR.
  - CAP: rsp_data<=mem_dout, rsp_valid<=1, go to IDLE.
  - WR: mem_we=1, mem_addr=latched address, go to IDLE.
    - WRITE: mem_din=cmd_data.
    - SET: mem_din=mem_dout | (1<<bit).
    - CLR: mem_din=mem_dout & ~(1<<bit).
    - TGL: mem_din=mem_dout ^ (1<<bit).
  - CLR: mem_we=1, mem_addr=counter, mem_din=0, counter++. Leave to IDLE after writing address DEPTH-1. The counter is ADDR_W+1 bits wide, so it does not wrap.
- IDLE drives mem_addr=0, mem_din=0, mem_we=0.
- mem_we is gated with rst_n: no write occurs in any cycle where rst_n=0.
- A reserved op makes no memory access and produces no rsp_valid.

## Timing

- Reset values: state IDLE, cmd_ready=1, busy=0, rsp_valid=0, rsp_data=0, err=0, mem_we=0, mem_addr=0, mem_din=0, counter=0.
- Accept at edge k. Then:
  - READ: RD in cycle k+1, CAP in k+2, rsp_valid=1 in k+3, cmd_ready=1 in k+3.
  - SET/CLR/TGL: RD in k+1, write in k+2, cmd_ready=1 in k+3.
  - WRITE: write in k+1, cmd_ready=1 in k+2.
  - CLEAR_ALL: writes in cycles k+1..k+DEPTH, cmd_ready=1 in k+DEPTH+1.
  - Reserved: err=1 in k+1, cmd_ready stays 1.
- A command issued immediately after a write always reads the updated word, because its RD cycle follows the write edge.
- rsp_valid has no backpressure; the consumer must take it.
- Reset asserted mid-operation (including mid-CLEAR_ALL): from the reset edge the block is IDLE. Words not yet written stay unchanged. No partial RMW write is issued.
- cmd_valid held while busy is ignored; the command is accepted when the block returns to IDLE.

## Structure

- Shared package lights_pkg holds:
  - the op encodings (OP_READ..OP_CLEAR_ALL) and the state enum;
  - LIGHTS_WIDTH=16 and LIGHTS_DEPTH=2048;
  - the bit-modify function (op, word, bit) -> word.
- No sub-module is needed. The controller is one module, lights_cmd_ctrl, and instantiates nothing.
- The top level wires mem_* to the lights BRAM instance.

## Test plan

- Reset, then WRITE addr 5 data 16'hA5A5, then READ addr 5 -> rsp_valid pulse 3 cycles after accept, rsp_data=16'hA5A5.
- Starting from 16'h0000 at addr 7: SET bit 3, TGL bit 15, CLR bit 3, READ -> rsp_data=16'h8000. Each bit op holds cmd_ready low for exactly 2 cycles.
- Back-to-back SET addr 9 bit 0 then SET addr 9 bit 1, with cmd_valid held continuously -> READ returns 16'h0003 (no lost RMW).
- Fill addr 0, 1000 and 2047 with 16'hFFFF, then CLEAR_ALL -> busy high 2048 cycles and mem_we high 2048 cycles; READ of each address returns 16'h0000.
- Reserved op 6 -> err pulse of 1 cycle, mem_we never asserted, cmd_ready stays 1.
- Assert rst_n=0 at CLEAR_ALL cycle 100 -> mem_we=0 that cycle, block IDLE afterwards, addr 1000 still reads 16'hFFFF, addr 50 reads 16'h0000.

Source files
------------

// File: rtl/lights_pkg.sv
// Shared definitions for the lights state memory command path:
// opcodes, controller states, geometry and the single-bit modify helper.
package lights_pkg;

  localparam int unsigned LIGHTS_WIDTH = 16;
  localparam int unsigned LIGHTS_DEPTH = 2048;

  typedef enum logic [2:0] {
    OP_READ      = 3'd0,
    OP_WRITE     = 3'd1,
    OP_SET       = 3'd2,
    OP_CLR       = 3'd3,
    OP_TGL       = 3'd4,
    OP_CLEAR_ALL = 3'd5,
    OP_RSV6      = 3'd6,
    OP_RSV7      = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_WR,
    ST_CLR
  } state_e;

  function automatic logic [LIGHTS_WIDTH-1:0] bit_modify(
    input op_e                     op,
    input logic [LIGHTS_WIDTH-1:0] word,
    input logic [3:0]              idx
  );
    logic [LIGHTS_WIDTH-1:0] mask;
    mask = LIGHTS_WIDTH'(1) << idx;
    case (op)
      OP_SET:  bit_modify = word | mask;
      OP_CLR:  bit_modify = word & ~mask;
      OP_TGL:  bit_modify = word ^ mask;
      default: bit_modify = word;
    endcase
  endfunction

endpackage

// File: rtl/lights_cmd_ctrl.sv
// Command front-end for the lights BRAM: word read/write, bit set/clear/toggle
// via read-modify-write, and a bulk clear sweeping every address.
module lights_cmd_ctrl
  import lights_pkg::*;
#(
  parameter int unsigned WIDTH  = LIGHTS_WIDTH,
  parameter int unsigned DEPTH  = LIGHTS_DEPTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_bit,
  input  logic [WIDTH-1:0]  cmd_data,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              err,
  output logic              busy,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WIDTH-1:0]  mem_din,
  input  logic [WIDTH-1:0]  mem_dout
);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          bit_q, bit_d;
  logic [WIDTH-1:0]    data_q, data_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                err_q, err_d;

  logic                we_c;
  logic [ADDR_W-1:0]   addr_c;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    bit_d       = bit_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    err_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = op_e'(cmd_op);
          addr_d = cmd_addr;
          bit_d  = cmd_bit;
          data_d = cmd_data;
          case (op_e'(cmd_op))
            OP_READ, OP_SET, OP_CLR, OP_TGL: state_d = ST_RD;
            OP_WRITE:                        state_d = ST_WR;
            OP_CLEAR_ALL: begin
              state_d = ST_CLR;
              cnt_d   = '0;
            end
            default:                         err_d = 1'b1;
          endcase
        end
      end
      ST_RD:  state_d = (op_q == OP_READ) ? ST_CAP : ST_WR;
      ST_CAP: begin
        rsp_data_d  = mem_dout;
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_WR:  state_d = ST_IDLE;
      ST_CLR: begin
        cnt_d = cnt_q + (ADDR_W+1)'(1);
        if (cnt_q == (ADDR_W+1)'(DEPTH - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_READ;
      addr_q      <= '0;
      bit_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      bit_q       <= bit_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  // Memory port decodes from registered state only; the RMW write data must
  // fold in mem_dout combinationally since the read lands in the WR cycle.
  always_comb begin
    we_c    = 1'b0;
    addr_c  = '0;
    mem_din = '0;
    case (state_q)
      ST_RD, ST_CAP: addr_c = addr_q;
      ST_WR: begin
        we_c    = 1'b1;
        addr_c  = addr_q;
        mem_din = (op_q == OP_WRITE) ? data_q : bit_modify(op_q, mem_dout, bit_q);
      end
      ST_CLR: begin
        we_c   = 1'b1;
        addr_c = cnt_q[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  assign mem_we    = we_c & rst_n;
  assign mem_addr  = 32'(addr_c);
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lights_cmd_ctrl.sv
// Directed bench for lights_cmd_ctrl with a behavioural 2048x16 BRAM attached.
module tb_lights_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [10:0] cmd_addr;
  logic [3:0]  cmd_bit;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        err;
  logic        busy;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;

  logic [15:0] mem [0:2047];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lights_cmd_ctrl #(.WIDTH(16), .DEPTH(2048), .ADDR_W(11)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_bit(cmd_bit), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .err(err), .busy(busy),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[10:0]] <= mem_din;
    mem_dout <= mem[mem_addr[10:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for cmd_ready, presents one command and returns in cycle k+1.
  task automatic issue(input logic [2:0] op, input logic [10:0] a,
                       input logic [3:0] b, input logic [15:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 5000) begin
      step();
      n++;
    end
    chk("issue_ready", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_addr = a; cmd_bit = b; cmd_data = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [10:0] a, input logic [15:0] d);
    issue(3'd1, a, 4'd0, d);
    step();
  endtask

  task automatic do_read(input string tag, input logic [10:0] a, input logic [15:0] exp);
    issue(3'd0, a, 4'd0, 16'h0);
    chk({tag, "_rv_k1"}, 32'(rsp_valid), 32'd0);
    step();
    chk({tag, "_rv_k2"}, 32'(rsp_valid), 32'd0);
    step();
    chk({tag, "_rv_k3"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_data"}, 32'(rsp_data), 32'(exp));
    chk({tag, "_ready_k3"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_bitop(input string tag, input logic [2:0] op, input logic [10:0] a,
                          input logic [3:0] b, input logic [15:0] exp_din);
    issue(op, a, b, 16'h0);
    chk({tag, "_ready_k1"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_we_k1"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr_k1"}, mem_addr, 32'(a));
    step();
    chk({tag, "_ready_k2"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_we_k2"}, 32'(mem_we), 32'd1);
    chk({tag, "_din_k2"}, 32'(mem_din), 32'(exp_din));
    step();
    chk({tag, "_ready_k3"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int n, busy_cnt, we_cnt, we_seen;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_bit = '0; cmd_data = '0;
    step();
    step();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_din", 32'(mem_din), 32'd0);
    rst_n = 1'b1;
    step();

    // WRITE then READ
    issue(3'd1, 11'd5, 4'd0, 16'hA5A5);
    chk("wr_we", 32'(mem_we), 32'd1);
    chk("wr_addr", mem_addr, 32'd5);
    chk("wr_din", 32'(mem_din), 32'h0000A5A5);
    chk("wr_ready_k1", 32'(cmd_ready), 32'd0);
    step();
    chk("wr_ready_k2", 32'(cmd_ready), 32'd1);
    chk("wr_we_k2", 32'(mem_we), 32'd0);
    do_read("rd5", 11'd5, 16'hA5A5);
    step();
    chk("rd5_pulse_end", 32'(rsp_valid), 32'd0);
    chk("rd5_hold", 32'(rsp_data), 32'h0000A5A5);

    // Bit ops on addr 7
    do_bitop("set3", 3'd2, 11'd7, 4'd3, 16'h0008);
    do_bitop("tgl15", 3'd4, 11'd7, 4'd15, 16'h8008);
    do_bitop("clr3", 3'd3, 11'd7, 4'd3, 16'h8000);
    do_read("rd7", 11'd7, 16'h8000);

    // Back-to-back SETs with cmd_valid held
    issue(3'd2, 11'd9, 4'd0, 16'h0);
    cmd_valid = 1'b1;
    cmd_bit = 4'd1;
    n = 0;
    while (!cmd_ready && n < 10) begin
      step();
      n++;
    end
    chk("b2b_busy_cycles", 32'(n), 32'd2);
    step();
    cmd_valid = 1'b0;
    step();
    chk("b2b_second_din", 32'(mem_din), 32'h00000003);
    step();
    do_read("rd9", 11'd9, 16'h0003);

    // Fill then CLEAR_ALL
    do_write(11'd0, 16'hFFFF);
    do_write(11'd1000, 16'hFFFF);
    do_write(11'd2047, 16'hFFFF);
    issue(3'd5, 11'd0, 4'd0, 16'h0);
    chk("clr_first_addr", mem_addr, 32'd0);
    busy_cnt = 0; we_cnt = 0;
    while (busy && busy_cnt < 3000) begin
      if (mem_we) we_cnt++;
      busy_cnt++;
      step();
    end
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd2048);
    chk("clr_we_cycles", 32'(we_cnt), 32'd2048);
    do_read("clr_rd0", 11'd0, 16'h0000);
    do_read("clr_rd1000", 11'd1000, 16'h0000);
    do_read("clr_rd2047", 11'd2047, 16'h0000);

    // Reserved opcode
    step();
    issue(3'd6, 11'd3, 4'd0, 16'h0);
    chk("rsv_err", 32'(err), 32'd1);
    chk("rsv_ready", 32'(cmd_ready), 32'd1);
    chk("rsv_we", 32'(mem_we), 32'd0);
    chk("rsv_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    chk("rsv_err_end", 32'(err), 32'd0);
    chk("rsv_we_k2", 32'(mem_we), 32'd0);

    // Reset in the middle of CLEAR_ALL
    do_write(11'd1000, 16'hFFFF);
    do_write(11'd50, 16'hFFFF);
    issue(3'd5, 11'd0, 4'd0, 16'h0);
    we_seen = 0;
    for (int i = 0; i < 99; i++) step();
    chk("mid_clr_addr", mem_addr, 32'd99);
    chk("mid_clr_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we_gated", 32'(mem_we), 32'd0);
    step();
    rst_n = 1'b1;
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (mem_we) we_seen++;
      step();
    end
    chk("post_rst_no_we", 32'(we_seen), 32'd0);
    do_read("rst_rd1000", 11'd1000, 16'hFFFF);
    do_read("rst_rd50", 11'd50, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
